// File: rtl/npc_bpred.sv
// Fetch-stage next-PC generator: owns the fetch PC, predicts from a direct-mapped
// BTB with 2-bit direction counters, and redirects/flushes on EX mispredicts.
module npc_bpred #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ENTRIES  = 64,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [31:0]      pc,
    output logic             pred_taken,
    output logic [31:0]      pred_npc,
    input  logic             ex_valid,
    input  logic [1:0]       ex_kind,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pred_npc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        if (c == 2'b11) return 2'b11;
        else return c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        if (c == 2'b00) return 2'b00;
        else return c - 2'd1;
    endfunction

    logic             btb_valid_r  [ENTRIES];
    logic [TAG_W-1:0] btb_tag_r    [ENTRIES];
    logic [31:0]      btb_target_r [ENTRIES];
    logic [1:0]       btb_ctr_r    [ENTRIES];

    logic [31:0]      pc_r;
    logic             flush_r;
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    logic [IDX_W-1:0] lk_idx_s;
    logic             lk_hit_s;
    logic             pred_taken_s;
    logic [31:0]      pred_npc_s;

    logic             res_s;
    logic             jump_s;
    logic             taken_s;
    logic [31:0]      actual_npc_s;
    logic             mispred_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] ex_tag_s;
    logic             ex_hit_s;
    logic             wr_en_s;
    logic [1:0]       wr_ctr_s;
    logic [31:0]      wr_target_s;

    // Zero-latency lookup of the current fetch PC.
    always_comb begin
        lk_idx_s     = pc_r[IDX_W+1:2];
        lk_hit_s     = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == pc_r[31:IDX_W+2]);
        pred_taken_s = lk_hit_s && btb_ctr_r[lk_idx_s][1];
        if (pred_taken_s) begin
            pred_npc_s = btb_target_r[lk_idx_s];
        end else begin
            pred_npc_s = pc_r + 32'd4;
        end
    end

    // Decode the EX resolution and detect a mispredict.
    always_comb begin
        case (ex_kind)
            2'd0:       begin res_s = ex_valid; jump_s = 1'b0; end
            2'd1, 2'd2: begin res_s = ex_valid; jump_s = 1'b1; end
            default:    begin res_s = 1'b0;     jump_s = 1'b0; end
        endcase
        taken_s = ex_taken || jump_s;
        if (taken_s) begin
            actual_npc_s = ex_target;
        end else begin
            actual_npc_s = ex_pc + 32'd4;
        end
        mispred_s = res_s && (actual_npc_s != ex_pred_npc);
        ex_idx_s  = ex_pc[IDX_W+1:2];
        ex_tag_s  = ex_pc[31:IDX_W+2];
        ex_hit_s  = btb_valid_r[ex_idx_s] && (btb_tag_r[ex_idx_s] == ex_tag_s);
    end

    // Next contents of the resolved entry; unconditional jumps pin the counter high.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_ctr_s    = btb_ctr_r[ex_idx_s];
        wr_target_s = btb_target_r[ex_idx_s];
        if (res_s && taken_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = ex_target;
            if (jump_s) begin
                wr_ctr_s = 2'b11;
            end else if (ex_hit_s) begin
                wr_ctr_s = ctr_inc(btb_ctr_r[ex_idx_s]);
            end else begin
                wr_ctr_s = 2'b10;
            end
        end else if (res_s && ex_hit_s) begin
            wr_en_s  = 1'b1;
            wr_ctr_s = ctr_dec(btb_ctr_r[ex_idx_s]);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // BTB storage; a write is visible to lookups from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= {TAG_W{1'b0}};
                btb_target_r[i] <= 32'h0000_0000;
                btb_ctr_r[i]    <= 2'b01;
            end
        end else if (wr_en_s) begin
            btb_valid_r[ex_idx_s]  <= 1'b1;
            btb_tag_r[ex_idx_s]    <= ex_tag_s;
            btb_target_r[ex_idx_s] <= wr_target_s;
            btb_ctr_r[ex_idx_s]    <= wr_ctr_s;
        end
    end

    // Fetch PC: a mispredict redirect overrides a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            flush_r <= 1'b0;
        end else if (mispred_s) begin
            pc_r    <= actual_npc_s;
            flush_r <= 1'b1;
        end else if (stall) begin
            pc_r    <= pc_r;
            flush_r <= 1'b0;
        end else begin
            pc_r    <= pred_npc_s;
            flush_r <= 1'b0;
        end
    end

    // Resolution and mispredict statistics, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r  <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (res_s) begin
                branch_cnt_r <= branch_cnt_r + CNT_ONE;
            end
            if (mispred_s) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
            end
        end
    end

    assign pc          = pc_r;
    assign flush       = flush_r;
    assign pred_taken  = pred_taken_s;
    assign pred_npc    = pred_npc_s;
    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: reset, stall, BTB allocation, counter hysteresis,
// aliasing, stall-vs-redirect priority, same-cycle lookup/update and PC wrap.
module tb_npc_bpred;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        ex_valid;
    logic [1:0]  ex_kind;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_npc;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int fails  = 0;

    npc_bpred #(.RESET_PC(32'h0000_0000), .ENTRIES(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_npc(pred_npc),
        .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_npc(ex_pred_npc),
        .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [1:0] k, input logic [31:0] a, input logic t,
                           input logic [31:0] tgt, input logic [31:0] pnpc);
        ex_valid = 1'b1; ex_kind = k; ex_pc = a; ex_taken = t;
        ex_target = tgt; ex_pred_npc = pnpc;
        tick();
        ex_valid = 1'b0;
    endtask

    // Not-taken mispredict of the instruction before a; no BTB change since a-4 misses.
    task automatic redirect_to(input logic [31:0] a);
        resolve(2'd0, a - 32'd4, 1'b0, 32'h0000_0000, 32'h0000_1000);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (pred_npc !== 32'h4) begin fails++; $display("FAIL reset_pred_npc got=%h exp=%h", pred_npc, 32'h4); end
        checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
        tick(); tick(); tick();
        checks++; if (pc !== 32'hC) begin fails++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'hC); end
        #3 rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || flush !== 1'b0) begin fails++; $display("FAIL midrun_reset pc=%h flush=%b exp=0/0", pc, flush); end
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h4) begin fails++; $display("FAIL reset_pred got=%b/%h exp=0/4", pred_taken, pred_npc); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checks++; if (pc !== 32'h4 || pred_taken !== 1'b0) begin fails++; $display("FAIL step4 pc=%h pt=%b exp=4/0", pc, pred_taken); end
        tick();
        checks++; if (pc !== 32'h8 || pred_taken !== 1'b0) begin fails++; $display("FAIL step8 pc=%h pt=%b exp=8/0", pc, pred_taken); end
    endtask

    task automatic test_stall();
        tick(); tick();
        checks++; if (pc !== 32'h10) begin fails++; $display("FAIL stall_pre got=%h exp=%h", pc, 32'h10); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h10) begin fails++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, pc, 32'h10); end
        end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h14) begin fails++; $display("FAIL stall_release got=%h exp=%h", pc, 32'h14); end
    endtask

    task automatic test_cold_taken();
        resolve(2'd0, 32'h20, 1'b1, 32'h40, 32'h24);
        checks++; if (pc !== 32'h40 || flush !== 1'b1) begin fails++; $display("FAIL cold_redirect pc=%h flush=%b exp=40/1", pc, flush); end
        checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin fails++; $display("FAIL cold_cnt got=%0d/%0d exp=1/1", branch_cnt, mispred_cnt); end
        tick();
        checks++; if (pc !== 32'h44 || flush !== 1'b0) begin fails++; $display("FAIL cold_flush_drop pc=%h flush=%b exp=44/0", pc, flush); end
        redirect_to(32'h20);
        checks++; if (pc !== 32'h20 || pred_taken !== 1'b1 || pred_npc !== 32'h40) begin fails++; $display("FAIL cold_predict pc=%h pt=%b npc=%h exp=20/1/40", pc, pred_taken, pred_npc); end
    endtask

    task automatic test_hysteresis();
        resolve(2'd0, 32'h20, 1'b0, 32'h40, 32'h40);
        checks++; if (pc !== 32'h24 || flush !== 1'b1) begin fails++; $display("FAIL hyst_nt_redirect pc=%h flush=%b exp=24/1", pc, flush); end
        redirect_to(32'h20);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h24) begin fails++; $display("FAIL hyst_ctr01 pt=%b npc=%h exp=0/24", pred_taken, pred_npc); end
        resolve(2'd0, 32'h20, 1'b1, 32'h40, 32'h40);
        checks++; if (pc !== 32'h24 || flush !== 1'b0) begin fails++; $display("FAIL hyst_correct pc=%h flush=%b exp=24/0", pc, flush); end
        resolve(2'd0, 32'h20, 1'b1, 32'h40, 32'h40);
        checks++; if (branch_cnt !== 32'd6 || mispred_cnt !== 32'd4) begin fails++; $display("FAIL hyst_cnt got=%0d/%0d exp=6/4", branch_cnt, mispred_cnt); end
        redirect_to(32'h20);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h40) begin fails++; $display("FAIL hyst_ctr11 pt=%b npc=%h exp=1/40", pred_taken, pred_npc); end
        resolve(2'd0, 32'h20, 1'b0, 32'h40, 32'h24);
        checks++; if (pc !== 32'h40 || flush !== 1'b0) begin fails++; $display("FAIL hyst_nt_correct pc=%h flush=%b exp=40/0", pc, flush); end
        redirect_to(32'h20);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h40) begin fails++; $display("FAIL hyst_ctr10 pt=%b npc=%h exp=1/40", pred_taken, pred_npc); end
        checks++; if (branch_cnt !== 32'd9 || mispred_cnt !== 32'd6) begin fails++; $display("FAIL hyst_cnt2 got=%0d/%0d exp=9/6", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_aliasing();
        redirect_to(32'h120);
        checks++; if (pc !== 32'h120 || pred_taken !== 1'b0 || pred_npc !== 32'h124) begin fails++; $display("FAIL alias_miss pc=%h pt=%b npc=%h exp=120/0/124", pc, pred_taken, pred_npc); end
        resolve(2'd2, 32'h120, 1'b0, 32'h300, 32'h124);
        checks++; if (pc !== 32'h300 || flush !== 1'b1) begin fails++; $display("FAIL alias_jr pc=%h flush=%b exp=300/1", pc, flush); end
        redirect_to(32'h20);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h24) begin fails++; $display("FAIL alias_evicted pt=%b npc=%h exp=0/24", pred_taken, pred_npc); end
        redirect_to(32'h120);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h300) begin fails++; $display("FAIL alias_jr_hit pt=%b npc=%h exp=1/300", pred_taken, pred_npc); end
        checks++; if (branch_cnt !== 32'd13 || mispred_cnt !== 32'd10) begin fails++; $display("FAIL alias_cnt got=%0d/%0d exp=13/10", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_simultaneous();
        stall = 1'b1;
        resolve(2'd1, 32'h50, 1'b0, 32'h80, 32'h54);
        checks++; if (pc !== 32'h80 || flush !== 1'b1) begin fails++; $display("FAIL stall_vs_mispred pc=%h flush=%b exp=80/1", pc, flush); end
        tick();
        checks++; if (pc !== 32'h80 || flush !== 1'b0) begin fails++; $display("FAIL stall_after pc=%h flush=%b exp=80/0", pc, flush); end
        stall = 1'b0;
    endtask

    task automatic test_same_cycle();
        resolve(2'd0, 32'h120, 1'b0, 32'h0, 32'h124);
        checks++; if (pc !== 32'h84 || flush !== 1'b0) begin fails++; $display("FAIL same_prep pc=%h flush=%b exp=84/0", pc, flush); end
        redirect_to(32'h120);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h300) begin fails++; $display("FAIL same_ctr10 pt=%b npc=%h exp=1/300", pred_taken, pred_npc); end
        resolve(2'd0, 32'h120, 1'b0, 32'h0, 32'h124);
        checks++; if (pc !== 32'h300 || flush !== 1'b0) begin fails++; $display("FAIL same_old_pred pc=%h flush=%b exp=300/0", pc, flush); end
        redirect_to(32'h120);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h124) begin fails++; $display("FAIL same_ctr01 pt=%b npc=%h exp=0/124", pred_taken, pred_npc); end
        checks++; if (branch_cnt !== 32'd18 || mispred_cnt !== 32'd13) begin fails++; $display("FAIL same_cnt got=%0d/%0d exp=18/13", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_wrap_reserved();
        redirect_to(32'hFFFF_FFFC);
        checks++; if (pc !== 32'hFFFF_FFFC || pred_npc !== 32'h0) begin fails++; $display("FAIL wrap_npc pc=%h npc=%h exp=fffffffc/0", pc, pred_npc); end
        tick();
        checks++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        resolve(2'd3, 32'h20, 1'b1, 32'h999, 32'h0);
        checks++; if (pc !== 32'h4 || flush !== 1'b0) begin fails++; $display("FAIL reserved_kind pc=%h flush=%b exp=4/0", pc, flush); end
        checks++; if (branch_cnt !== 32'd19 || mispred_cnt !== 32'd14) begin fails++; $display("FAIL reserved_cnt got=%0d/%0d exp=19/14", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_reset_clears();
        #2 rst = 1'b1;
        #1;
        checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || pc !== 32'h0) begin fails++; $display("FAIL rst_clear cnt=%0d/%0d pc=%h exp=0/0/0", branch_cnt, mispred_cnt, pc); end
        tick();
        rst = 1'b0;
        redirect_to(32'h120);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h124) begin fails++; $display("FAIL rst_btb_clear pt=%b npc=%h exp=0/124", pred_taken, pred_npc); end
        checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin fails++; $display("FAIL rst_cnt_restart got=%0d/%0d exp=1/1", branch_cnt, mispred_cnt); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        ex_valid = 1'b0; ex_kind = 2'd0; ex_pc = 32'h0; ex_taken = 1'b0;
        ex_target = 32'h0; ex_pred_npc = 32'h0;
        test_reset();
        test_stall();
        test_cold_taken();
        test_hysteresis();
        test_aliasing();
        test_simultaneous();
        test_same_cycle();
        test_wrap_reserved();
        test_reset_clears();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/npc_bpred.md
# npc_bpred

Parametrised next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the head of the fetch stage of the pipelined CPU and owns the fetch PC register. Each cycle it predicts the next fetch address from the BTB. It accepts branch/jump resolutions from EX, redirects fetch and pulses a flush on a mispredict, and keeps branch and mispredict statistics counters.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC value loaded on reset
- ENTRIES, 64, number of BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CNT_W, 32, width of the statistics counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold fetch PC (load-use bubble)
- pc  out  32  current fetch PC (registered)
- pred_taken  out  1  combinational prediction for `pc`
- pred_npc  out  32  combinational predicted next PC for `pc`
- ex_valid  in  1  EX resolves a control instruction this cycle
- ex_kind  in  2  0 = conditional branch, 1 = direct jump (j/jal), 2 = register jump (jr/jalr), 3 = reserved (ignored)
- ex_pc  in  32  PC of the resolving instruction
- ex_taken  in  1  actual outcome (forced to 1 internally for kinds 1 and 2)
- ex_target  in  32  actual target address
- ex_pred_npc  in  32  PC that was fetched after this instruction (carried down the pipe)
- flush  out  1  registered, one-cycle pulse; kill IF/ID and ID/EX contents
- branch_cnt  out  CNT_W  resolved control instructions
- mispred_cnt  out  CNT_W  mispredicts

## Operation
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0]. Index = PC[IDX_W+1:2]. PC[1:0] are ignored everywhere.
- Lookup (combinational on `pc`):
  - hit = valid & tag match
  - pred_taken = hit & ctr[1]
  - pred_npc = pred_taken ? target : pc+4
- Resolution (ex_valid=1, ex_kind≠3):
  - actual_npc = taken ? ex_target : ex_pc+4
  - mispredict = (actual_npc ≠ ex_pred_npc)
- BTB update on resolution:
  - Taken and miss: allocate/overwrite the entry with valid=1, new tag, target = ex_target, ctr = 2'b10. For kinds 1 and 2, ctr = 2'b11.
  - Taken and hit: target = ex_target; ctr saturating increment (max 11). Kinds 1 and 2 set ctr = 11.
  - Not taken and hit: ctr saturating decrement (min 00). The entry stays valid.
  - Not taken and miss: no change.
- Next PC priority, applied at the clock edge:
  1. mispredict: pc ← actual_npc, flush ← 1. This wins over stall.
  2. stall: pc holds, flush ← 0.
  3. otherwise: pc ← pred_npc, flush ← 0.
- Statistics:
  - branch_cnt += 1 on each resolution.
  - mispred_cnt += 1 on each mispredict.
  - Both wrap modulo 2^CNT_W.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 0xFFFF_FFFC+4 = 0x0000_0000.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC, flush = 0
  - all valid = 0, all ctr = 01
  - branch_cnt = mispred_cnt = 0
  - pred_taken = 0 and pred_npc = RESET_PC+4 while in reset.
- Prediction has zero latency: it is combinational from `pc` through the BTB registers.
- Redirect latency is 1 cycle: a resolution in cycle N gives pc = actual_npc and flush = 1 in cycle N+1. flush returns to 0 in cycle N+2 unless another mispredict occurs.
- BTB writes take effect at the edge ending cycle N and are visible to lookups from cycle N+1.
- Same-index lookup and update in one cycle: the lookup uses the pre-update contents.
- Statistics counters update at the same edge as the BTB.
- ex_kind = 3 or ex_valid = 0 means no BTB change, no counter change and no redirect.

## Test plan
- Reset and sequencing:
  - Stimulus: assert rst mid-run, then release.
  - Required: pc = 0 and flush = 0 immediately; pc then steps 0x0 → 0x4 → 0x8; pred_taken = 0 throughout.
- Stall:
  - Stimulus: hold stall = 1 for 3 cycles while pc = 0x10.
  - Required: pc stays 0x10; after release, pc = 0x14.
- Cold taken branch:
  - Stimulus: ex_valid, kind = 0, ex_pc = 0x20, taken, ex_target = 0x40, ex_pred_npc = 0x24.
  - Required next cycle: pc = 0x40, flush = 1 for one cycle, mispred_cnt = 1, branch_cnt = 1.
  - Later, when fetching 0x20: pred_taken = 1, pred_npc = 0x40.
- Counter hysteresis on entry 0x20 (starting at 10):
  - Not-taken → 01: pred_taken = 0.
  - Taken, taken → 11.
  - Not-taken → 10: pred_taken still 1.
  - A correctly predicted resolution (ex_pred_npc = actual_npc) gives no flush and increments branch_cnt only.
- Aliasing (ENTRIES = 64):
  - Stimulus: 0x20 allocated, then fetch 0x120 (same index, different tag).
  - Required: miss, pred_npc = 0x124.
  - Then a taken jr at 0x120 → 0x300 overwrites the entry; fetching 0x20 now misses.
- Simultaneous events:
  - Stimulus: stall = 1 together with a mispredict (actual_npc = 0x80).
  - Required: pc = 0x80, flush = 1.
  - Stimulus: a same-cycle lookup of the updated index.
  - Required: returns the old prediction.
